// File: rtl/acc_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_arbiter_pkg : shared sizing and output-beat type for acc_arbiter  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package acc_arbiter_pkg;

   localparam int N_CORE = 4;
   localparam int N_ACC  = 3;
   localparam int DATA_W = 32;

   localparam int N_SLOT = N_CORE * N_ACC;
   localparam int CORE_W = $clog2(N_CORE);
   localparam int ACC_W  = $clog2(N_ACC);
   localparam int SLOT_W = $clog2(N_SLOT);

   typedef struct packed {
      logic [ACC_W-1:0]  acc;
      logic [CORE_W-1:0] core;
      logic [DATA_W-1:0] data;
   } acc_beat_t;

endpackage
`default_nettype wire

// File: rtl/acc_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_arbiter_if : per-core request bundle and single output port      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface acc_arbiter_if;
   import acc_arbiter_pkg::*;

   logic [N_CORE-1:0][N_ACC-1:0]             req_valid;
   logic [N_CORE-1:0][N_ACC-1:0][DATA_W-1:0] req_data;
   logic [N_CORE-1:0][N_ACC-1:0]             req_ready;

   logic              out_valid;
   logic [ACC_W-1:0]  out_acc;
   logic [CORE_W-1:0] out_core;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              drained;

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_acc, out_core, out_data, drained
   );

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_acc, out_core, out_data, drained
   );

endinterface
`default_nettype wire

// File: rtl/acc_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick, first request at/after ptr  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int S  = 12,
   parameter int SW = $clog2(S)
) (
   input  logic [S-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [S-1:0]  grant,
   output logic [SW-1:0] grant_idx,
   output logic          any
);

   localparam logic [SW:0] S_VAL = (SW+1)'(S);

   logic [S-1:0]  rot;
   logic [SW-1:0] off;
   logic [SW:0]   sum;

   // Rotating the doubled vector puts slot ptr at bit 0, so the lowest set
   // bit is the distance from ptr to the winner.
   always_comb begin
      rot = S'({req, req} >> ptr);
      off = '0;
      for (int k = S - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = SW'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= S_VAL) begin
         sum = sum - S_VAL;
      end
      grant_idx = sum[SW-1:0];
      any       = |req;
      grant     = '0;
      if (any) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/acc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_arbiter : round-robin share of the accumulator-update port        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module acc_arbiter
   import acc_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   acc_arbiter_if.slave  bus
);

   logic [N_SLOT-1:0] req_flat;
   logic [N_SLOT-1:0] grant;
   logic [SLOT_W-1:0] win_idx;
   logic              any_req;
   logic              load;
   acc_beat_t         win_beat;

   acc_beat_t         beat_q, beat_d;
   logic              out_valid_q, out_valid_d;
   logic [SLOT_W-1:0] ptr_q, ptr_d;

   always_comb begin
      req_flat = '0;
      for (int c = 0; c < N_CORE; c++) begin
         for (int a = 0; a < N_ACC; a++) begin
            req_flat[c*N_ACC + a] = bus.req_valid[c][a];
         end
      end
   end

   rr_pick #(.S(N_SLOT), .SW(SLOT_W)) u_pick (
      .req       (req_flat),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (win_idx),
      .any       (any_req)
   );

   assign load = !out_valid_q || bus.out_ready;

   always_comb begin
      win_beat = '0;
      for (int c = 0; c < N_CORE; c++) begin
         for (int a = 0; a < N_ACC; a++) begin
            if (grant[c*N_ACC + a]) begin
               win_beat.acc  = ACC_W'(a);
               win_beat.core = CORE_W'(c);
               win_beat.data = bus.req_data[c][a];
            end
         end
      end
   end

   // The grant is only offered when the output stage can take it this cycle.
   always_comb begin
      bus.req_ready = '0;
      if (load && !rst) begin
         for (int c = 0; c < N_CORE; c++) begin
            for (int a = 0; a < N_ACC; a++) begin
               bus.req_ready[c][a] = grant[c*N_ACC + a];
            end
         end
      end
   end

   always_comb begin
      beat_d      = beat_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (any_req) begin
            beat_d      = win_beat;
            out_valid_d = 1'b1;
            ptr_d       = (win_idx == SLOT_W'(N_SLOT - 1)) ? '0 : win_idx + SLOT_W'(1);
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = beat_q.acc;
   assign bus.out_core  = beat_q.core;
   assign bus.out_data  = beat_q.data;
   assign bus.drained   = !any_req && !out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_acc_arbiter : directed and random checks against a slot-level model|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_acc_arbiter;
   import acc_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   acc_arbiter_if bus ();

   acc_arbiter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [N_SLOT-1:0] req_v;
   logic [DATA_W-1:0] req_d [N_SLOT];
   logic              out_rdy;
   bit                drop_on_grant;

   always_comb begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      for (int c = 0; c < N_CORE; c++) begin
         for (int a = 0; a < N_ACC; a++) begin
            bus.req_valid[c][a] = req_v[c*N_ACC + a];
            bus.req_data[c][a]  = req_d[c*N_ACC + a];
         end
      end
      bus.out_ready = out_rdy;
   end

   // Reference model: output register contents and the round-robin start slot.
   bit                m_valid;
   int                m_slot;
   logic [DATA_W-1:0] m_data;
   int                m_ptr;

   int n_total = 0;
   int n_bad   = 0;

   logic [N_SLOT-1:0] s_ready;
   logic              s_valid;
   int                s_core, s_acc, s_slot;
   logic [DATA_W-1:0] s_data;
   logic              s_drained;
   int                beats [N_SLOT];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N_SLOT-1:0] flat_ready();
      logic [N_SLOT-1:0] r;
      r = '0;
      for (int c = 0; c < N_CORE; c++) begin
         for (int a = 0; a < N_ACC; a++) begin
            r[c*N_ACC + a] = bus.req_ready[c][a];
         end
      end
      return r;
   endfunction

   function automatic int ready_slot(input logic [N_SLOT-1:0] r);
      int w;
      w = -1;
      for (int s = 0; s < N_SLOT; s++) begin
         if (r[s]) w = s;
      end
      return w;
   endfunction

   task automatic cycle();
      logic [N_SLOT-1:0] e_ready;
      bit load, found;
      int win;
      @(negedge clk);
      load  = !m_valid || out_rdy;
      found = 0;
      win   = -1;
      if (!rst && load) begin
         for (int i = 0; i < N_SLOT; i++) begin
            int s;
            s = (m_ptr + i) % N_SLOT;
            if (!found && req_v[s]) begin
               found = 1;
               win   = s;
            end
         end
      end
      e_ready = '0;
      if (found) e_ready[win] = 1'b1;

      s_ready   = flat_ready();
      s_valid   = bus.out_valid;
      s_core    = int'(bus.out_core);
      s_acc     = int'(bus.out_acc);
      s_slot    = s_core * N_ACC + s_acc;
      s_data    = bus.out_data;
      s_drained = bus.drained;

      check_val("req_ready", s_ready, e_ready);
      check_val("out_valid", s_valid, m_valid);
      if (m_valid) begin
         check_val("out_core", s_core, m_slot / N_ACC);
         check_val("out_acc",  s_acc,  m_slot % N_ACC);
         check_val("out_data", s_data, m_data);
      end
      check_val("drained", s_drained, (req_v == '0) && !m_valid);
      if (!rst && s_valid && out_rdy && s_slot < N_SLOT) beats[s_slot]++;

      @(posedge clk);
      if (rst) begin
         m_valid = 0;
         m_slot  = 0;
         m_data  = '0;
         m_ptr   = 0;
      end else if (load) begin
         if (found) begin
            m_valid = 1;
            m_slot  = win;
            m_data  = req_d[win];
            m_ptr   = (win + 1) % N_SLOT;
         end else begin
            m_valid = 0;
         end
      end
      #1;
      if (drop_on_grant) req_v = req_v & ~s_ready;
   endtask

   initial begin
      int b3, b4, b9, exp_w;
      logic [N_SLOT-1:0] one;
      req_v         = '0;
      out_rdy       = 1'b0;
      drop_on_grant = 0;
      m_valid = 0; m_slot = 0; m_data = '0; m_ptr = 0;
      for (int s = 0; s < N_SLOT; s++) begin
         req_d[s] = '0;
         beats[s] = 0;
      end
      one = N_SLOT'(1);

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cycle();
      check_val("rst_drained", s_drained, 1'b1);
      check_val("rst_valid", s_valid, 1'b0);
      req_v[7] = 1'b1;
      req_d[7] = 32'h3F80_0000;
      out_rdy  = 1'b1;
      drop_on_grant = 1;
      cycle();
      check_val("rst_ready", s_ready, '0);
      rst = 1'b0;

      // Single request from core 2, accumulator 1
      cycle();
      check_val("t1_grant", s_ready, one << 7);
      cycle();
      check_val("t1_valid", s_valid, 1'b1);
      check_val("t1_core", s_core, 2);
      check_val("t1_acc", s_acc, 1);
      check_val("t1_data", s_data, 32'h3F80_0000);
      cycle();
      check_val("t1_drained", s_drained, 1'b1);

      // All slots at once after reset: strict slot order, back-to-back beats
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int s = 0; s < N_SLOT; s++) begin
         req_v[s] = 1'b1;
         req_d[s] = 32'hA000_0000 + 32'(s);
      end
      for (int i = 0; i < N_SLOT; i++) begin
         cycle();
         check_val("t2_order", s_ready, one << i);
         if (i > 0) check_val("t2_beat", {s_valid, 8'(s_slot)}, {1'b1, 8'(i - 1)});
      end
      req_v[0]  = 1'b1;
      req_v[11] = 1'b1;
      cycle();
      check_val("t2_beat_last", {s_valid, 8'(s_slot)}, {1'b1, 8'd11});
      check_val("t2_wrap", s_ready, one);
      repeat (2) cycle();

      // Backpressure
      repeat (2) cycle();
      out_rdy  = 1'b0;
      req_v[2] = 1'b1;
      req_d[2] = 32'h0000_0222;
      cycle();
      req_v[5] = 1'b1;
      req_d[5] = 32'h0000_0555;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_val("t3_hold_ready", s_ready, '0);
         check_val("t3_hold_out", {s_valid, s_data}, {1'b1, 32'h0000_0222});
      end
      out_rdy = 1'b1;
      cycle();
      check_val("t3_grant", s_ready, one << 5);
      cycle();
      check_val("t3_next", {s_valid, 8'(s_slot), s_data}, {1'b1, 8'd5, 32'h0000_0555});

      // Fairness between two permanent requesters
      repeat (2) cycle();
      drop_on_grant = 0;
      req_v[0] = 1'b1;
      req_v[7] = 1'b1;
      exp_w = 7;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check_val("t4_grant", ready_slot(s_ready), exp_w);
         exp_w = (exp_w == 7) ? 0 : 7;
      end

      // Withdrawn request
      req_v = '0;
      drop_on_grant = 1;
      repeat (2) cycle();
      b3 = beats[3];
      b9 = beats[9];
      out_rdy  = 1'b0;
      req_v[9] = 1'b1;
      req_d[9] = 32'h0000_0999;
      cycle();
      req_v[3] = 1'b1;
      req_d[3] = 32'h0000_0333;
      repeat (3) cycle();
      req_v[3] = 1'b0;
      out_rdy  = 1'b1;
      repeat (3) cycle();
      check_val("t5_withdraw", beats[3] - b3, 0);
      check_val("t5_other", beats[9] - b9, 1);

      // Reset while the output holds a beat
      out_rdy  = 1'b0;
      req_v[4] = 1'b1;
      req_d[4] = 32'h0000_0444;
      cycle();
      cycle();
      check_val("t5_full", s_valid, 1'b1);
      b4  = beats[4];
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      check_val("t5_rst_valid", s_valid, 1'b0);
      req_v   = '1;
      out_rdy = 1'b1;
      cycle();
      check_val("t5_rst_ptr", s_ready, one);
      check_val("t5_rst_beat", beats[4] - b4, 0);
      req_v = '0;
      drop_on_grant = 0;
      repeat (2) cycle();

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         out_rdy = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 149) == 0);
         cycle();
         for (int s = 0; s < N_SLOT; s++) begin
            if (!req_v[s]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_v[s] = 1'b1;
                  req_d[s] = $urandom;
               end
            end else if (s_ready[s]) begin
               if ($urandom_range(0, 3) == 0) req_d[s] = $urandom;
               else req_v[s] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
               req_v[s] = 1'b0;
            end
         end
      end
      rst = 1'b0;
      req_v = '0;
      out_rdy = 1'b1;
      repeat (3) cycle();
      check_val("end_drained", s_drained, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
